// File: rtl/pc_redirect_ctrl.sv
// Control-flow redirect sequencer: latches the Execute-stage target, hands it to Fetch over a
// valid/ready handshake, then squashes the wrong-path slots. Define BRANCH_STATS_EN for branch counters.
module pc_redirect_ctrl #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcSrcE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic [PC_W-1:0] pcTargetE,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            stallF,
  output logic            flushD,
  output logic            flushE,
  output logic            misalign_err,
  output logic            busy
`ifdef BRANCH_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] br_total_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_e;

  // The counter only ever holds FLUSH_CYCLES-2 down to 0.
  localparam int FW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [FW-1:0]   cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    mis_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pcSrcE) begin
          pc_d    = {pcTargetE[PC_W-1:2], 2'b00};
          mis_d   = |pcTargetE[1:0];
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (fetch_ready) begin
          if (FLUSH_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            cnt_d   = FLUSH_LOAD;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode state only; fetch_ready is the sole input reaching an output (stallF).
  assign redirect_valid = (state_q == REDIRECT);
  assign flushE         = (state_q == REDIRECT);
  assign flushD         = (state_q != IDLE);
  assign busy           = (state_q != IDLE);
  assign stallF         = (state_q == REDIRECT) && !fetch_ready;
  assign redirect_pc    = pc_q;
  assign misalign_err   = mis_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] total_q, taken_q;

  always_ff @(posedge clk) begin
    if (!rst_n || stats_clr) begin
      total_q <= '0;
      taken_q <= '0;
    end else if (state_q == IDLE) begin
      if ((branchE || jumpE) && !(&total_q)) total_q <= total_q + 1'b1;
      if (pcSrcE && !(&taken_q))             taken_q <= taken_q + 1'b1;
    end
  end

  assign br_total_cnt = total_q;
  assign br_taken_cnt = taken_q;
`else
  logic unused_stats_inputs;
  assign unused_stats_inputs = branchE ^ jumpE;
`endif

endmodule
